sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
- Single-clock FIFO controller that drives the dual-port validity-check memory directly.
- Accepts push/pop requests and generates the memory write/read enables and addresses.
- Tracks occupancy and produces full/empty, watermark and error flags.
- Data never passes through this block: wdata goes straight to the memory; rdata/valid return from the memory one cycle after mem_rd_en.

Parameters:
- ADDR_WIDTH, 8: memory address width.
- RAM_DEPTH, 1<<ADDR_WIDTH: FIFO depth; must equal the memory depth (power of two).
- AF_LEVEL, RAM_DEPTH-2: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  single clock; wire to both memory wr_clk and rd_clk.
- rst_n  in  1  asynchronous active-low reset.
- push  in  1  write request; data is presented to memory wdata in the same cycle.
- pop  in  1  read request.
- err_clr  in  1  clears sticky error flags (used only with the optional feature).
- mem_wr_en  out  1  memory write enable.
- mem_waddr  out  ADDR_WIDTH  memory write address.
- mem_rd_en  out  1  memory read enable.
- mem_raddr  out  ADDR_WIDTH  memory read address.
- count  out  ADDR_WIDTH+1  current occupancy, 0..RAM_DEPTH.
- full  out  1  count == RAM_DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  watermark flag.
- almost_empty  out  1  watermark flag.
- overflow  out  1  push rejected.
- underflow  out  1  pop rejected.

Behaviour:
- Reset (async, rst_n low):
  - wptr = rptr = 0, count = 0.
  - empty = 1, almost_empty = 1; full = almost_full = 0.
  - overflow = underflow = 0.
  - Reset mid-operation discards all contents immediately.
- Acceptance (combinational):
  - rd_acc = pop & ~empty.
  - wr_acc = push & (~full | rd_acc).
- Memory outputs:
  - mem_wr_en = wr_acc; mem_rd_en = rd_acc.
  - mem_waddr = wptr; mem_raddr = rptr (registered pointers).
- Pointers:
  - On wr_acc, wptr <= wptr+1; on rd_acc, rptr <= rptr+1.
  - Both wrap modulo RAM_DEPTH (natural ADDR_WIDTH overflow).
- count <= count + wr_acc - rd_acc; never exceeds RAM_DEPTH and never goes below 0.
- Flags are registered and derived from the next count value, so they are correct in the same cycle count updates. There is no combinational path from push/pop to the flags.
- Read latency: memory rdata/valid appear 1 cycle after mem_rd_en. The controller makes no guarantee about rdata while valid = 0.
- Simultaneous push and pop:
  - When empty: only the push is accepted; count becomes 1.
  - When full: both are accepted and waddr == raddr. The memory returns the old (oldest) word because its read is registered before the write lands. count stays RAM_DEPTH.
  - Otherwise: both are accepted; count unchanged.
- Errors:
  - overflow is set for one cycle after push & ~wr_acc.
  - underflow is set for one cycle after pop & ~rd_acc.
  - A rejected request has no effect on pointers or count.
- err_clr is ignored unless the optional feature is enabled.

Optional Feature:
- Macro FIFO_ERR_STICKY_EN.
- Defined: overflow/underflow are sticky. They set on the error event and hold until err_clr = 1. If err_clr and a new error occur in the same cycle, set wins.
- Undefined: overflow/underflow are single-cycle pulses, registered one cycle after the rejected request; err_clr is unused.

Test Plan:
- All tests use ADDR_WIDTH=3 (depth 8), AF_LEVEL=6, AE_LEVEL=2.
- Reset: assert rst_n=0 mid-stream with count=5 -> immediately count=0, empty=1, almost_empty=1, pointers 0, no mem enables.
- Fill: 8 pushes of data 0x10..0x17 -> mem_waddr 0..7. almost_full rises after the 6th push, full after the 8th. A 9th push gives mem_wr_en=0, overflow=1, count=8.
- Drain: 8 pops after fill -> mem_raddr 0..7, memory valid=1 with rdata 0x10..0x17 one cycle after each pop. empty=1 after the last pop. A 9th pop gives mem_rd_en=0 and underflow=1.
- Wrap: push 5, pop 5, push 6 -> mem_waddr sequence 5,6,7,0,1,2. count=6, almost_full=1, data read back in order.
- Simultaneous: push&pop while empty -> count=1. push&pop while full -> both enables high, waddr==raddr, rdata = oldest word, count=8, no overflow.
- Sticky errors: with FIFO_ERR_STICKY_EN, overflow stays 1 for 10 cycles until err_clr=1, then reads 0. Without the macro, overflow is a 1-cycle pulse.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: drives memory enables/addresses, tracks occupancy, flags and errors.
// Optional build macro FIFO_ERR_STICKY_EN makes overflow/underflow sticky until err_clr.
module sync_fifo_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int AF_LEVEL   = RAM_DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  err_clr,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAM_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

  logic [ADDR_WIDTH-1:0] wptr_r, rptr_r;
  logic [CW-1:0]         count_r, count_nxt_s;
  logic                  full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
  logic                  rd_acc_s, wr_acc_s, ovf_evt_s, unf_evt_s;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside it.
  always_comb begin
    rd_acc_s  = pop & ~empty_r;
    wr_acc_s  = push & (~full_r | rd_acc_s);
    ovf_evt_s = push & ~wr_acc_s;
    unf_evt_s = pop & ~rd_acc_s;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + ONE_C;
      2'b01:   count_nxt_s = count_r - ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  assign mem_wr_en    = wr_acc_s;
  assign mem_rd_en    = rd_acc_s;
  assign mem_waddr    = wptr_r;
  assign mem_raddr    = rptr_r;
  assign count        = count_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

  // Flags are computed from the next count so they line up with the count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= {ADDR_WIDTH{1'b0}};
      rptr_r  <= {ADDR_WIDTH{1'b0}};
      count_r <= ZERO_C;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
    end else begin
      if (wr_acc_s) wptr_r <= wptr_r + 1'b1;
      if (rd_acc_s) rptr_r <= rptr_r + 1'b1;
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == ZERO_C);
      af_r    <= (count_nxt_s >= AF_C);
      ae_r    <= (count_nxt_s <= AE_C);
    end
  end

`ifdef FIFO_ERR_STICKY_EN
  // Sticky errors: a new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_evt_s | (ovf_r & ~err_clr);
      unf_r <= unf_evt_s | (unf_r & ~err_clr);
    end
  end
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = err_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_evt_s;
      unf_r <= unf_evt_s;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl: queue-based reference model, behavioural memory, random + directed stimulus.
module tb_sync_fifo_ctrl;
  localparam int AW = 3, DEPTH = 8, AF = 6, AE = 2;

  logic clk = 1'b0, rst_n = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
  logic [7:0] wdata = 8'd0;
  logic mem_wr_en, mem_rd_en, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [AW:0] count;

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata;
  logic valid;

  int errors = 0, checks = 0;
  int wcnt = 0, rcnt = 0, n_c = 0;
  bit ovf_exp = 1'b0, unf_exp = 1'b0, m_rd, m_wr, c_rd, c_wr;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];

  sync_fifo_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .err_clr(err_clr),
    .mem_wr_en(mem_wr_en), .mem_waddr(mem_waddr), .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit p, bit q, bit c, logic [7:0] d);
    push = p; pop = q; err_clr = c; wdata = d;
    @(posedge clk);
    #1;
  endtask

  // Dual-port memory with registered read (read sees the old word on a same-address write).
  always @(posedge clk) if (mem_wr_en) mem[mem_waddr] <= wdata;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      rdata <= 8'd0;
    end else begin
      valid <= mem_rd_en;
      if (mem_rd_en) rdata <= mem[mem_raddr];
    end
  end

  // Reference model: FIFO contents as a queue; reads leave before writes arrive in the same cycle.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        wcnt = 0; rcnt = 0; ovf_exp = 1'b0; unf_exp = 1'b0;
        model_q.delete(); exp_q.delete();
      end else begin
        m_rd = pop && (model_q.size() > 0);
        m_wr = push && ((model_q.size() < DEPTH) || m_rd);
        if (m_rd) begin exp_q.push_back(model_q.pop_front()); rcnt++; end
        if (m_wr) begin model_q.push_back(wdata); wcnt++; end
`ifdef FIFO_ERR_STICKY_EN
        ovf_exp = (push && !m_wr) || (ovf_exp && !err_clr);
        unf_exp = (pop && !m_rd) || (unf_exp && !err_clr);
`else
        ovf_exp = push && !m_wr;
        unf_exp = pop && !m_rd;
`endif
      end
    end
  end

  // Monitor: compare outputs against the model and pop the scoreboard on every valid read.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        n_c  = model_q.size();
        c_rd = pop && (n_c > 0);
        c_wr = push && ((n_c < DEPTH) || c_rd);
        chk("mem_wr_en", int'(mem_wr_en), int'(c_wr));
        chk("mem_rd_en", int'(mem_rd_en), int'(c_rd));
        chk("mem_waddr", int'(mem_waddr), wcnt % DEPTH);
        chk("mem_raddr", int'(mem_raddr), rcnt % DEPTH);
        chk("count", int'(count), n_c);
        chk("full", int'(full), int'(n_c == DEPTH));
        chk("empty", int'(empty), int'(n_c == 0));
        chk("almost_full", int'(almost_full), int'(n_c >= AF));
        chk("almost_empty", int'(almost_empty), int'(n_c <= AE));
        chk("overflow", int'(overflow), int'(ovf_exp));
        chk("underflow", int'(underflow), int'(unf_exp));
        if (valid) begin
          if (exp_q.size() == 0) chk("rdata_unexpected", 1, 0);
          else chk("rdata", int'(rdata), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int pb[4] = '{70, 30, 50, 55};
    int qb[4] = '{30, 70, 50, 45};
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0, 8'(32'd16 + i));
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'b0, 8'd0);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 8'(32'd32 + i));
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 8'(32'd48 + i));
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 1'b0, 8'h77);
    drive(1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 8'(32'd96 + i));
    drive(1'b1, 1'b1, 1'b0, 8'hA5);
    drive(1'b1, 1'b0, 1'b0, 8'hEE);
    repeat (10) drive(1'b0, 1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 1'b1, 8'd0);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 8'd0);
    repeat (9) drive(1'b0, 1'b1, 1'b0, 8'd0);
    repeat (4) drive(1'b0, 1'b0, 1'b1, 8'd0);
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 100; i++)
        drive(($urandom_range(0, 99) < pb[s]), ($urandom_range(0, 99) < qb[s]),
              ($urandom_range(0, 9) == 0), 8'($urandom));
    repeat (10) drive(1'b0, 1'b1, 1'b0, 8'd0);
    repeat (2) drive(1'b0, 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 8'(32'd192 + i));
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    chk("pre_reset_count", int'(count), 5);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_almost_empty", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_almost_full", int'(almost_full), 0);
    chk("rst_waddr", int'(mem_waddr), 0);
    chk("rst_raddr", int'(mem_raddr), 0);
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_rd_en", int'(mem_rd_en), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_underflow", int'(underflow), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 60; i++)
      drive(($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 50),
            ($urandom_range(0, 9) == 0), 8'($urandom));
    repeat (10) drive(1'b0, 1'b1, 1'b0, 8'd0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'd0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
